// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared types and constants for the bit-serial adder controller.
//            Holds the controller state encoding and the default operand width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  // Controller states
  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;

  // Default operand and sum width in bits
  localparam int SA_DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

`default_nettype wire

// File: rtl/serial_adder_ctrl_full_adder.sv
// ============================================================================
// Module   : full_adder
// Purpose  : 1-bit full adder cell, the only arithmetic element of the
//            bit-serial adder datapath.
// Ports    : a, b    - addend bits
//            cin     - carry in
//            s       - sum bit
//            cout    - carry out
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// ============================================================================
// Module   : serial_adder_ctrl
// Purpose  : Bit-serial adder controller. Adds two WIDTH-bit operands over
//            WIDTH clock cycles by time-sharing a single full_adder cell,
//            LSB first, keeping the carry in a register between cycles.
//            A one-cycle done pulse marks a final result.
// Ports    : clk   - rising-edge clock
//            rst   - synchronous active-high reset
//            start - request pulse, only honoured in IDLE
//            a, b  - WIDTH-bit operands, captured on accept
//            cin   - carry in, captured on accept
//            busy  - high while the addition is running
//            done  - one-cycle completion pulse
//            sum   - WIDTH-bit result register
//            cout  - final carry out
//            ovf   - signed overflow (only with SERIAL_ADDER_OVF_EN)
// Config   : `define SERIAL_ADDER_OVF_EN to add the signed overflow output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter needs at least one bit even when WIDTH is 1
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_next;

  full_adder u_full_adder (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit i lands at i.
  // Written as shift/or so it stays legal for WIDTH == 1.
  assign sum_next = (sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  assign cout = carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SA_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      sa    <= '0;
      sb    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        SA_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= SA_RUN;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end

        SA_RUN: begin
          sum   <= sum_next;
          carry <= fa_cout;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          if (cnt == CNT_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= SA_DONE;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is the register; carry out is the cell output
            ovf   <= carry ^ fa_cout;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        SA_DONE: begin
          done  <= 1'b0;
          state <= SA_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= SA_IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder_ctrl

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Purpose  : Self-checking bench for serial_adder_ctrl at WIDTH = 8.
//            Table of directed additions, back-to-back start handling,
//            mid-run reset abort, and a partial operand sweep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one add from IDLE and wait for done. Called #1 after an edge.
  task automatic do_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic [W-1:0] es,
                        input logic eco, input logic eov,
                        input string nm, input bit full);
    int lat;
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tcin;
    lat   = 0;
    do begin
      tick();
      start = 1'b0;
      lat++;
      if (full && lat == 1) check({nm, " busy after accept"}, 32'(busy), 32'd1);
    end while (!done && lat < 30);
    if (!done) begin
      check({nm, " done timeout"}, 32'(done), 32'd1);
    end else begin
      if (full) begin
        check({nm, " latency"}, 32'(lat), 32'(W + 1));
        check({nm, " busy at done"}, 32'(busy), 32'd0);
      end
      check({nm, " cout:sum"}, {23'd0, cout, sum}, {23'd0, eco, es});
`ifdef SERIAL_ADDER_OVF_EN
      check({nm, " ovf"}, 32'(ovf), 32'(eov));
`else
      if (eov === 1'bx) $display("note: unexpected X in expected ovf");
`endif
    end
    tick();
    if (full) check({nm, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] bl [8];
    logic [W:0]   r;
    logic         eov;

    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[8] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};

    bl[0] = 8'h00; bl[1] = 8'h01; bl[2] = 8'h7F; bl[3] = 8'h80;
    bl[4] = 8'hFF; bl[5] = 8'h55; bl[6] = 8'hAA; bl[7] = 8'h3C;

    // Reset state
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Directed table
    for (int i = 0; i < 9; i++)
      do_add(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, vt[i].ov,
             $sformatf("vec%0d", i), 1'b1);

    // Back-to-back: start ignored in RUN and in DONE
    start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick();                       // E0, now RUN cycle 1
    start = 1'b0;
    tick();                       // RUN cycle 2
    tick();                       // RUN cycle 3
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20 && !done; k++) tick();
    check("b2b done seen", 32'(done), 32'd1);
    check("b2b cout:sum", {23'd0, cout, sum}, {23'd0, 1'b1, 8'hFF});
    start = 1'b1;                 // pulse during DONE
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      tick();
    end
    check("b2b extra done", 32'(ndone), 32'd0);
    check("b2b idle busy", 32'(busy), 32'd0);
    check("b2b sum held", 32'(sum), 32'hFF);
    do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "b2b next", 1'b1);

    // Reset in the 4th RUN cycle aborts the add
    start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
    tick();                       // RUN cycle 1
    start = 1'b0;
    tick(); tick(); tick();       // RUN cycle 4
    check("abort busy before rst", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      tick();
    end
    check("abort no done", 32'(ndone), 32'd0);
    do_add(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, "after abort", 1'b1);

    // Sweep: every a against a spread of b values and both carries
    for (int ia = 0; ia < 256; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++) begin
          r   = {1'b0, 8'(ia)} + {1'b0, bl[ib]} + 9'(ic);
          eov = (ia[7] == bl[ib][7]) && (r[7] != ia[7]);
          do_add(8'(ia), bl[ib], 1'(ic), r[7:0], r[8], eov, "sweep", 1'b0);
        end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_serial_adder_ctrl

`default_nettype wire
